// File: rtl/pipeline_pkg.sv
// Shared pipeline types: ALU operation codes, SrcA select encoding and the
// EX-stage control bundle used by the ID/EX operand stage.
package pipeline_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;
    localparam logic [3:0] ALU_BNE  = 4'b1011;
    localparam logic [3:0] ALU_BGE  = 4'b1100;
    localparam logic [3:0] ALU_BLT  = 4'b1101;

    typedef enum logic [1:0] {
        A_REG  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2,
        A_RSVD = 2'd3
    } a_sel_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '{reg_write: 1'b0, mem_read: 1'b0,
                                         mem_write: 1'b0, branch: 1'b0};

endpackage

// File: rtl/forward_mux.sv
// Operand bypass select: MEM result beats WB result beats the stored operand;
// register x0 is never bypassed.
module forward_mux #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_i,
    input  logic [DATA_WIDTH-1:0]     op_i,
    input  logic                      mem_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_i,
    input  logic [DATA_WIDTH-1:0]     mem_result_i,
    input  logic                      wb_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0]     wb_result_i,
    output logic [DATA_WIDTH-1:0]     fwd_o
);

    logic rs_nonzero;
    logic mem_hit;
    logic wb_hit;

    assign rs_nonzero = (rs_i != '0);
    assign mem_hit    = mem_reg_write_i && (mem_rd_i == rs_i) && rs_nonzero;
    assign wb_hit     = wb_reg_write_i  && (wb_rd_i  == rs_i) && rs_nonzero;

    always_comb begin
        fwd_o = op_i;
        if (mem_hit) begin
            fwd_o = mem_result_i;
        end else if (wb_hit) begin
            fwd_o = wb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble insertion, capture-time WB
// bypass and combinational MEM/WB forwarding into the ALU operands.
module id_ex_operand_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic [DATA_WIDTH-1:0]     id_rd1,
    input  logic [DATA_WIDTH-1:0]     id_rd2,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
    input  logic [1:0]                id_a_sel,
    input  logic                      id_b_imm,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      id_branch,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]     mem_result,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_result,
    input  logic                      flush,
    input  logic                      hold,
    output logic                      stall_id,
    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     ex_src_a,
    output logic [DATA_WIDTH-1:0]     ex_src_b,
    output logic [OPCODE_LENGTH-1:0]  ex_operation,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [DATA_WIDTH-1:0]     ex_pc,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_branch
);

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     op1;
        logic [DATA_WIDTH-1:0]     op2;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [OPCODE_LENGTH-1:0]  alu_op;
        a_sel_t                    a_sel;
        logic                      b_imm;
        ex_ctrl_t                  ctrl;
    } ex_reg_t;

    ex_reg_t ex_q;
    ex_reg_t ex_d;

    logic [DATA_WIDTH-1:0] fwd1;
    logic [DATA_WIDTH-1:0] fwd2;
    logic [DATA_WIDTH-1:0] cap1;
    logic [DATA_WIDTH-1:0] cap2;
    logic                  load_use;

    forward_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs1 (
        .rs_i            (ex_q.rs1),
        .op_i            (ex_q.op1),
        .mem_reg_write_i (mem_reg_write),
        .mem_rd_i        (mem_rd),
        .mem_result_i    (mem_result),
        .wb_reg_write_i  (wb_reg_write),
        .wb_rd_i         (wb_rd),
        .wb_result_i     (wb_result),
        .fwd_o           (fwd1)
    );

    forward_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs2 (
        .rs_i            (ex_q.rs2),
        .op_i            (ex_q.op2),
        .mem_reg_write_i (mem_reg_write),
        .mem_rd_i        (mem_rd),
        .mem_result_i    (mem_result),
        .wb_reg_write_i  (wb_reg_write),
        .wb_rd_i         (wb_rd),
        .wb_result_i     (wb_result),
        .fwd_o           (fwd2)
    );

    // The register file is read before WB writes it, so a same-cycle WB
    // producer has to be picked up while the instruction is captured.
    assign cap1 = (wb_reg_write && (wb_rd == id_rs1) && (id_rs1 != '0)) ? wb_result : id_rd1;
    assign cap2 = (wb_reg_write && (wb_rd == id_rs2) && (id_rs2 != '0)) ? wb_result : id_rd2;

    assign load_use = id_valid && ex_q.valid && ex_q.ctrl.mem_read && (ex_q.rd != '0) &&
                      ((id_uses_rs1 && (ex_q.rd == id_rs1)) ||
                       (id_uses_rs2 && (ex_q.rd == id_rs2)));

    assign stall_id = load_use && !flush && !hold;

    always_comb begin
        ex_d = ex_q;
        if (flush || (!hold && (load_use || !id_valid))) begin
            ex_d        = '0;
            ex_d.ctrl   = BUBBLE_CTRL;
            ex_d.alu_op = OPCODE_LENGTH'(ALU_ADD);
        end else if (hold) begin
            // Keep re-latching the bypassed operands so a producer retiring
            // from WB during the stall is still seen afterwards.
            ex_d.op1 = fwd1;
            ex_d.op2 = fwd2;
        end else begin
            ex_d.valid          = 1'b1;
            ex_d.pc             = id_pc;
            ex_d.op1            = cap1;
            ex_d.op2            = cap2;
            ex_d.imm            = id_imm;
            ex_d.rs1            = id_rs1;
            ex_d.rs2            = id_rs2;
            ex_d.rd             = id_rd;
            ex_d.alu_op         = id_alu_op;
            ex_d.a_sel          = a_sel_t'(id_a_sel);
            ex_d.b_imm          = id_b_imm;
            ex_d.ctrl.reg_write = id_reg_write;
            ex_d.ctrl.mem_read  = id_mem_read;
            ex_d.ctrl.mem_write = id_mem_write;
            ex_d.ctrl.branch    = id_branch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    always_comb begin
        case (ex_q.a_sel)
            A_REG:   ex_src_a = fwd1;
            A_PC:    ex_src_a = ex_q.pc;
            default: ex_src_a = '0;
        endcase
    end

    assign ex_src_b      = ex_q.b_imm ? ex_q.imm : fwd2;
    assign ex_store_data = fwd2;
    assign ex_valid      = ex_q.valid;
    assign ex_operation  = ex_q.alu_op;
    assign ex_pc         = ex_q.pc;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.valid && ex_q.ctrl.reg_write;
    assign ex_mem_read   = ex_q.valid && ex_q.ctrl.mem_read;
    assign ex_mem_write  = ex_q.valid && ex_q.ctrl.mem_write;
    assign ex_branch     = ex_q.valid && ex_q.ctrl.branch;

endmodule
